// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line and received-character outputs of the configurable UART receiver
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  modport slave (
    input  i_RX_Serial,
    output o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
  );
  modport master (
    output i_RX_Serial,
    input  o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable data bits, parity and stop bits, majority-voted sampling
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 195,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic          i_Clock,
  input logic          i_Rst_n,
  uart_rx_cfg_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q;
  logic                 s0_q, s1_q;
  logic [DATA_BITS-1:0] shift_q, byte_q;
  logic                 par_bit_q, stop_low_q, stop_high_q;
  logic                 dv_q, brk_q, perr_q, ferr_q;
  logic                 wrap, decide, maj, last_stop, is_break, perr_d;

  assign bus.o_RX_DV      = dv_q;
  assign bus.o_RX_Byte    = byte_q;
  assign bus.o_Parity_Err = perr_q;
  assign bus.o_Frame_Err  = ferr_q;
  assign bus.o_Break      = brk_q;

  // bit-period timing, 3-sample vote and end-of-character classification
  always_comb begin
    wrap      = cnt_q == LAST;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    decide    = cnt_q == MID + 1'b1;
    maj       = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    last_stop = idx_q == SLAST;
    is_break  = ~|shift_q && (PARITY == 0 || !par_bit_q) && !stop_high_q && !maj;
    perr_d    = PARITY != 0 && ((^shift_q ^ par_bit_q) == (PARITY == 2));
  end

  // synchroniser plus receive FSM; the edge that enters START counts as count 0
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      shift_q     <= '0;
      byte_q      <= '0;
      par_bit_q   <= 1'b0;
      stop_low_q  <= 1'b0;
      stop_high_q <= 1'b0;
      dv_q        <= 1'b0;
      brk_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rx_meta_q <= bus.i_RX_Serial;
      rx_s_q    <= rx_meta_q;
      dv_q      <= 1'b0;
      brk_q     <= 1'b0;
      if (cnt_q == MID - 1'b1) s0_q <= rx_s_q;
      if (cnt_q == MID) s1_q <= rx_s_q;
      cnt_q <= (state_q == IDLE || state_q == WAIT_HIGH) ? '0 : cnt_d;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          cnt_q   <= CW'(1);
        end
        START: if (decide && maj) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (wrap) begin
          state_q     <= DATA;
          idx_q       <= '0;
          stop_low_q  <= 1'b0;
          stop_high_q <= 1'b0;
        end
        DATA: begin
          if (decide) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (wrap) begin
            idx_q   <= idx_q == DLAST ? '0 : idx_q + 4'd1;
            state_q <= idx_q != DLAST ? DATA : (PARITY != 0 ? PAR : STOP);
          end
        end
        PAR: begin
          if (decide) par_bit_q <= maj;
          if (wrap) state_q <= STOP;
        end
        STOP: if (decide && !last_stop) begin
          stop_low_q  <= stop_low_q | !maj;
          stop_high_q <= stop_high_q | maj;
        end else if (decide) begin
          cnt_q <= '0;
          idx_q <= '0;
          if (is_break) begin
            brk_q   <= 1'b1;
            state_q <= WAIT_HIGH;
          end else begin
            dv_q    <= 1'b1;
            byte_q  <= shift_q;
            perr_q  <= perr_d;
            ferr_q  <= stop_low_q | !maj;
            state_q <= maj ? IDLE : WAIT_HIGH;
          end
        end else if (wrap) idx_q <= idx_q + 4'd1;
        WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: vector table, directed corner sequences and randomized frames against a frame-level model
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic line [3];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus_b ();
  uart_rx_cfg_if #(.DATA_BITS(7)) bus_c ();
  assign bus_a.i_RX_Serial = line[0];
  assign bus_b.i_RX_Serial = line[1];
  assign bus_c.i_RX_Serial = line[2];

  uart_rx_cfg #(.CLKS_PER_BIT(195), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.i_Clock(clk), .i_Rst_n(rst_n), .bus(bus_a));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_b (.i_Clock(clk), .i_Rst_n(rst_n), .bus(bus_b));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
    dut_c (.i_Clock(clk), .i_Rst_n(rst_n), .bus(bus_c));

  function automatic int cpb_of(input int w); return w == 0 ? 195 : 16; endfunction
  function automatic int nd_of(input int w);  return w == 2 ? 7 : 8; endfunction
  function automatic int pm_of(input int w);  return w == 0 ? 0 : (w == 1 ? 2 : 1); endfunction
  function automatic int ns_of(input int w);  return w == 2 ? 2 : 1; endfunction

  typedef struct {
    int         w;
    logic       dv, brk, perr, ferr;
    logic [8:0] dat;
    int         cyc;
  } ev_t;
  ev_t q[$];

  function automatic ev_t mk(input int w, input logic dv, brk, perr, ferr, input logic [8:0] dat);
    ev_t e;
    e.w = w; e.dv = dv; e.brk = brk; e.perr = perr; e.ferr = ferr; e.dat = dat; e.cyc = cyc;
    return e;
  endfunction

  // every DV or break strobe of any receiver becomes one event
  always @(negedge clk) begin
    if (bus_a.o_RX_DV || bus_a.o_Break)
      q.push_back(mk(0, bus_a.o_RX_DV, bus_a.o_Break, bus_a.o_Parity_Err, bus_a.o_Frame_Err, 9'(bus_a.o_RX_Byte)));
    if (bus_b.o_RX_DV || bus_b.o_Break)
      q.push_back(mk(1, bus_b.o_RX_DV, bus_b.o_Break, bus_b.o_Parity_Err, bus_b.o_Frame_Err, 9'(bus_b.o_RX_Byte)));
    if (bus_c.o_RX_DV || bus_c.o_Break)
      q.push_back(mk(2, bus_c.o_RX_DV, bus_c.o_Break, bus_c.o_Parity_Err, bus_c.o_Frame_Err, 9'(bus_c.o_RX_Byte)));
  end

  logic [8:0] last_dat [3];
  logic       last_perr [3];
  logic       last_ferr [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic hold(input int w, input logic v, input int n);
    line[w] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [8:0] d, input logic par, input logic [1:0] stp);
    hold(w, 1'b0, cpb_of(w));
    for (int i = 0; i < nd_of(w); i++) hold(w, d[i], cpb_of(w));
    if (pm_of(w) != 0) hold(w, par, cpb_of(w));
    for (int i = 0; i < ns_of(w); i++) hold(w, stp[i], cpb_of(w));
  endtask

  task automatic check_ev(input string nm, input int w, input logic dv, brk, perr, ferr, input logic [8:0] dat);
    chk({nm, " events"}, q.size(), 1);
    if (q.size() > 0) begin
      chk({nm, " dut"}, q[0].w, w);
      chk({nm, " dv"}, q[0].dv, dv);
      chk({nm, " break"}, q[0].brk, brk);
      chk({nm, " byte"}, q[0].dat, dat);
      chk({nm, " perr"}, q[0].perr, perr);
      chk({nm, " ferr"}, q[0].ferr, ferr);
    end
    q.delete();
    if (dv) begin
      last_dat[w] = dat; last_perr[w] = perr; last_ferr[w] = ferr;
    end
  endtask

  task automatic run_frame(input string nm, input int w, input logic [8:0] d, input logic par, input logic [1:0] stp,
                           input logic dv, brk, perr, ferr, input logic [8:0] dat);
    send_frame(w, d, par, stp);
    hold(w, 1'b1, cpb_of(w));
    check_ev(nm, w, dv, brk, perr, ferr, dat);
  endtask

  // frame-level reference: parity by counting ones, break as an all-zero frame
  task automatic model(input int w, input logic [8:0] d, input logic par, input logic [1:0] stp,
                       output logic dv, brk, perr, ferr, output logic [8:0] dat);
    logic [8:0] dm;
    int ones;
    logic any_low, all_low;
    dm = d & 9'((1 << nd_of(w)) - 1);
    ones = $countones(dm) + (par ? 1 : 0);
    any_low = !stp[0] || (ns_of(w) == 2 && !stp[1]);
    all_low = !stp[0] && (ns_of(w) == 1 || !stp[1]);
    brk  = dm == 0 && (pm_of(w) == 0 || !par) && all_low;
    dv   = !brk;
    dat  = brk ? last_dat[w] : dm;
    perr = brk ? last_perr[w] : (pm_of(w) != 0 && (ones % 2) != (pm_of(w) == 1 ? 1 : 0));
    ferr = brk ? last_ferr[w] : any_low;
  endtask

  typedef struct {
    int         w;
    logic [8:0] d;
    logic       par;
    logic [1:0] stp;
    logic       dv, brk, perr, ferr;
    logic [8:0] dat;
  } vec_t;
  vec_t tbl [13];

  localparam int LAT_A = 3 + 9 * 195 + (195 - 1) / 2 + 1;

  initial begin
    int t0;
    int w;
    logic [8:0] d;
    logic par, dv, brk, perr, ferr;
    logic [1:0] stp;
    logic [8:0] dat;
    tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0A5};
    tbl[1]  = '{0, 9'h000, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[2]  = '{1, 9'h007, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 9'h007};
    tbl[3]  = '{1, 9'h007, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 9'h007};
    tbl[4]  = '{1, 9'h000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 9'h007};
    tbl[5]  = '{1, 9'h0FF, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0FF};
    tbl[6]  = '{1, 9'h000, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000};
    tbl[7]  = '{2, 9'h055, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 9'h055};
    tbl[8]  = '{2, 9'h07F, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 9'h07F};
    tbl[9]  = '{2, 9'h07F, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 9'h07F};
    tbl[10] = '{2, 9'h000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h07F};
    tbl[11] = '{2, 9'h000, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 9'h000};
    tbl[12] = '{0, 9'h000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1; last_dat[i] = '0; last_perr[i] = 1'b0; last_ferr[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset dv", bus_a.o_RX_DV, 0);
    chk("reset break", bus_a.o_Break, 0);
    chk("reset byte", bus_a.o_RX_Byte, 0);
    chk("reset perr", bus_b.o_Parity_Err, 0);
    chk("reset ferr", bus_c.o_Frame_Err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].d, tbl[i].par, tbl[i].stp,
                tbl[i].dv, tbl[i].brk, tbl[i].perr, tbl[i].ferr, tbl[i].dat);

    t0 = cyc;
    send_frame(0, 9'h0A5, 1'b0, 2'b01);
    send_frame(0, 9'h03C, 1'b0, 2'b01);
    hold(0, 1'b1, 195);
    chk("b2b events", q.size(), 2);
    if (q.size() == 2) begin
      chk("latency first", q[0].cyc - t0, LAT_A);
      chk("b2b byte first", q[0].dat, 9'h0A5);
      chk("latency second", q[1].cyc - t0, LAT_A + 10 * 195);
      chk("b2b byte second", q[1].dat, 9'h03C);
    end
    q.delete();
    last_dat[0] = 9'h03C;

    hold(0, 1'b0, 195);
    for (int i = 0; i < 8; i++)
      if (i == 3) begin
        hold(0, 1'b1, 97); hold(0, 1'b0, 1); hold(0, 1'b1, 195 - 98);
      end else hold(0, 1'b1, 195);
    hold(0, 1'b1, 195);
    hold(0, 1'b1, 195);
    check_ev("spike", 0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0FF);

    hold(0, 1'b0, 40);
    hold(0, 1'b1, 2 * 195);
    chk("glitch events", q.size(), 0);
    chk("glitch byte", bus_a.o_RX_Byte, last_dat[0]);
    q.delete();

    hold(0, 1'b0, 12 * 195);
    hold(0, 1'b1, 2 * 195);
    check_ev("line break", 0, 1'b0, 1'b1, last_perr[0], last_ferr[0], last_dat[0]);
    run_frame("after break", 0, 9'h041, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 9'h041);

    send_frame(2, 9'h055, 1'b1, 2'b01);
    hold(2, 1'b0, 15 * 16);
    check_ev("stop2 low", 2, 1'b1, 1'b0, 1'b0, 1'b1, 9'h055);
    hold(2, 1'b1, 2 * 16);
    chk("held low events", q.size(), 0);
    q.delete();
    run_frame("after held low", 2, 9'h02A, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 9'h02A);

    for (int i = 0; i < 50; i++) begin
      w = 1 + (i % 2);
      d = 9'($urandom);
      par = 1'($urandom);
      stp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        d = '0; par = 1'b0; stp = 2'b00;
      end
      model(w, d, par, stp, dv, brk, perr, ferr, dat);
      run_frame($sformatf("rand%0d", i), w, d, par, stp, dv, brk, perr, ferr, dat);
      hold(w, 1'b1, cpb_of(w) * $urandom_range(0, 2));
    end

    run_frame("8n1 ferr", 0, 9'h012, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 9'h012);
    hold(0, 1'b0, 195);
    hold(0, 1'b1, 195);
    for (int i = 0; i < 3; i++) hold(0, 1'b0, 195);
    hold(0, 1'b0, 97);
    rst_n = 1'b0;
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe reset dv", bus_a.o_RX_DV, 0);
    chk("midframe reset break", bus_a.o_Break, 0);
    chk("midframe reset byte", bus_a.o_RX_Byte, 0);
    chk("midframe reset perr", bus_a.o_Parity_Err, 0);
    chk("midframe reset ferr", bus_a.o_Frame_Err, 0);
    rst_n = 1'b1;
    hold(0, 1'b1, 2 * 195);
    chk("midframe reset events", q.size(), 0);
    q.delete();
    run_frame("after reset", 0, 9'h081, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 9'h081);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
